cv32e40p_instr_mem_responder: RTL and testbench
===============================================

CV32E40P_INSTR_MEM_RESPONDER -- requirements
Module: cv32e40p_instr_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning byte-address width of the backing SRAM window (2^ADDR_WIDTH bytes).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning first byte address served; SHALL be 2^ADDR_WIDTH aligned.
REQ-003 SHALL have parameter RESP_LATENCY, default 1, legal 1..4, meaning cycles from grant to rvalid.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, legal 1..4, meaning the cap on granted-but-unanswered requests.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 instr_req_i  in  1  OBI address-phase request from the fetch side.
REQ-008 instr_addr_i  in  32  byte fetch address; bits [1:0] ignored.
REQ-009 instr_gnt_o  out  1  address-phase grant.
REQ-010 instr_rvalid_o  out  1  response valid; no ready (the initiator always accepts).
REQ-011 instr_rdata_o  out  32  response word.
REQ-012 instr_err_o  out  1  bus error, qualified by instr_rvalid_o.
REQ-013 stall_i  in  1  back-pressure: forces instr_gnt_o low.
REQ-014 sram_req_o  out  1  SRAM read strobe.
REQ-015 sram_addr_o  out  ADDR_WIDTH-2  SRAM word index.
REQ-016 sram_rdata_i  in  32  SRAM read data, valid exactly one cycle after sram_req_o.
REQ-017 busy_o  out  1  high when the outstanding count is nonzero.

Function
REQ-018 Grant rule: instr_gnt_o = instr_req_i & ~stall_i & ~rst & (outstanding < MAX_OUTSTANDING); combinational, no registered gnt.
REQ-019 Accepted transaction: cycle with instr_req_i & instr_gnt_o; at most one per cycle.
REQ-020 In range: (instr_addr_i - BASE_ADDR) < 2^ADDR_WIDTH, 32-bit unsigned subtraction with wrap.
REQ-021 In-range accept: sram_req_o=1 in the same cycle; sram_addr_o = offset[ADDR_WIDTH-1:2].
REQ-022 Out-of-range accept: sram_req_o=0; response carries instr_err_o=1, instr_rdata_o=32'h0.
REQ-023 A transaction accepted in cycle T SHALL produce exactly one instr_rvalid_o pulse in cycle T+RESP_LATENCY.
REQ-024 Responses SHALL be in acceptance order; back-to-back accepts give back-to-back rvalid.
REQ-025 RESP_LATENCY>1: SRAM data captured at T+1 and delayed through a RESP_LATENCY-1 stage register pipeline carrying {valid, err, data}.
REQ-026 instr_rdata_o and instr_err_o SHALL be 0 whenever instr_rvalid_o=0.
REQ-027 Outstanding counter, width $clog2(MAX_OUTSTANDING+1): +1 on accept, -1 on rvalid, unchanged if both in one cycle; never exceeds MAX_OUTSTANDING nor underflows.
REQ-028 MAX_OUTSTANDING < RESP_LATENCY SHALL be legal; the grant rule throttles throughput to MAX_OUTSTANDING per RESP_LATENCY cycles.
REQ-029 stall_i affects only new grants; in-flight responses complete on schedule.
REQ-030 sram_req_o SHALL be 0 except in in-range accept cycles.

Reset
REQ-031 While rst=1: instr_gnt_o=0, sram_req_o=0; after the first clk edge with rst=1, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, busy_o=0, counter=0, all pipeline valids=0.
REQ-032 Reset mid-operation SHALL drop all in-flight responses; no rvalid for pre-reset accepts.

Structure
REQ-033 Response entry struct {valid, err, rdata[31:0]} SHALL be defined in cv32e40p_pkg as instr_resp_t.
REQ-034 The delay line SHALL be a sub-module cv32e40p_instr_resp_pipe (parameter DEPTH, reset clears valids).
REQ-035 An assertion (under CV32E40P_ASSERT_ON) SHALL check parameter legality and instr_addr_i stability while instr_req_i & ~instr_gnt_o.

Verification
REQ-036 Defaults, req at 0x0000_0100 in cycle T, SRAM word 0x0041_0113 -> gnt at T, sram_addr_o=0x40, rvalid at T+1 with rdata 0x0041_0113, err=0.
REQ-037 RESP_LATENCY=3, MAX_OUTSTANDING=4, req held 6 cycles on 0x0,0x4,...,0x14 -> 6 grants, rvalids T+3..T+8 in order.
REQ-038 RESP_LATENCY=3, MAX_OUTSTANDING=2, req held -> gnt pattern 1,1,0,1,1,0...; counter never exceeds 2.
REQ-039 Req at 0x0001_0000 (ADDR_WIDTH=16) -> gnt, sram_req_o=0, next cycle rvalid=1, err=1, rdata=0.
REQ-040 stall_i=1 for 3 cycles with req high -> gnt=0 during stall, grant on first stall-free cycle; responses already in flight unaffected.
REQ-041 Assert rst one cycle after two accepts with RESP_LATENCY=3 -> no rvalid afterwards, busy_o=0, next accept after release behaves as REQ-036.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types for the instruction-memory responder slice.
// Response entries travel the delay line as one packed bundle.
package cv32e40p_pkg;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } instr_resp_t;

   localparam instr_resp_t RESP_IDLE = '{
      valid: 1'b0,
      err:   1'b0,
      rdata: 32'h0
   };

   function automatic logic in_window(
      logic [31:0] off,
      int unsigned aw
   );
      return (off >> aw) == 32'h0;
   endfunction

endpackage

// File: rtl/cv32e40p_instr_mem_responder_if.sv
// OBI instruction-side channel between the fetch unit and the responder.
// No rready: the initiator always accepts a response.
interface cv32e40p_instr_mem_responder_if;

   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;

   modport master (
      output instr_req_i,
      output instr_addr_i,
      input  instr_gnt_o,
      input  instr_rvalid_o,
      input  instr_rdata_o,
      input  instr_err_o
   );

   modport slave (
      input  instr_req_i,
      input  instr_addr_i,
      output instr_gnt_o,
      output instr_rvalid_o,
      output instr_rdata_o,
      output instr_err_o
   );

endinterface

// File: rtl/cv32e40p_instr_resp_pipe.sv
// Fixed-depth delay line for response entries.
// Reset empties every stage so in-flight responses are dropped.
module cv32e40p_instr_resp_pipe
   import cv32e40p_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  instr_resp_t in_resp,
   output instr_resp_t out_resp
);

   instr_resp_t stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESP_IDLE;
         end
      end else begin
         stage_q[0] <= in_resp;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign out_resp = stage_q[DEPTH-1];

endmodule

// File: rtl/cv32e40p_instr_mem_responder.sv
// OBI instruction-fetch responder backed by a single-cycle SRAM window.
// Fixed-latency, in-order responses with a cap on outstanding grants.
module cv32e40p_instr_mem_responder
   import cv32e40p_pkg::*;
#(
   parameter int          ADDR_WIDTH      = 16,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          RESP_LATENCY    = 1,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   cv32e40p_instr_mem_responder_if.slave bus,
   input  logic                  stall_i,
   output logic                  sram_req_o,
   output logic [ADDR_WIDTH-3:0] sram_addr_o,
   input  logic [31:0]           sram_rdata_i,
   output logic                  busy_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT =
      CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_eff;
   logic [31:0]      offset;
   logic             in_range;
   logic             gnt;
   logic             accept;
   logic             rsp_fire;
   logic             s1_valid_q;
   logic             s1_err_q;
   instr_resp_t      s1_resp;
   instr_resp_t      out_resp;

   assign offset   = bus.instr_addr_i - BASE_ADDR;
   assign in_range = in_window(offset, ADDR_WIDTH);

   // A slot freed by this cycle's response may be reused at once,
   // giving MAX_OUTSTANDING grants per RESP_LATENCY cycles.
   assign cnt_eff = cnt_q - CNT_W'(rsp_fire);

   assign gnt = bus.instr_req_i & ~stall_i & ~rst
              & (cnt_eff < MAX_CNT);

   assign accept      = bus.instr_req_i & gnt;
   assign sram_req_o  = accept & in_range;
   assign sram_addr_o = offset[ADDR_WIDTH-1:2];

   assign bus.instr_gnt_o = gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= accept;
         s1_err_q   <= accept & ~in_range;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      s1_resp       = RESP_IDLE;
      s1_resp.valid = s1_valid_q;
      s1_resp.err   = s1_valid_q & s1_err_q;
      if (s1_valid_q & ~s1_err_q) begin
         s1_resp.rdata = sram_rdata_i;
      end
   end

   if (RESP_LATENCY > 1) begin : g_pipe
      cv32e40p_instr_resp_pipe #(
         .DEPTH (RESP_LATENCY - 1)
      ) u_pipe (
         .clk      (clk),
         .rst      (rst),
         .in_resp  (s1_resp),
         .out_resp (out_resp)
      );
   end else begin : g_direct
      assign out_resp = s1_resp;
   end

   assign rsp_fire = out_resp.valid & ~rst;

   assign bus.instr_rvalid_o = rsp_fire;
   assign bus.instr_err_o    = rsp_fire & out_resp.err;
   assign bus.instr_rdata_o  = rsp_fire ? out_resp.rdata
                                        : 32'h0;

   always_comb begin
      cnt_d = cnt_q;
      unique case (1'b1)
         (accept & ~rsp_fire): cnt_d = cnt_q + CNT_W'(1);
         (rsp_fire & ~accept): cnt_d = cnt_q - CNT_W'(1);
         default:              cnt_d = cnt_q;
      endcase
   end

   assign busy_o = cnt_q != '0;

`ifdef CV32E40P_ASSERT_ON
   localparam bit PARAM_OK =
      (RESP_LATENCY >= 1) && (RESP_LATENCY <= 4) &&
      (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING <= 4) &&
      (ADDR_WIDTH >= 3) && (ADDR_WIDTH <= 31) &&
      ((BASE_ADDR & ((32'h1 << ADDR_WIDTH) - 32'h1)) == 32'h0);

   a_params : assert property (@(posedge clk) PARAM_OK);

   a_addr_stable : assert property (
      @(posedge clk) disable iff (rst)
      (bus.instr_req_i && !gnt)
      |=> (bus.instr_req_i && $stable(bus.instr_addr_i))
   );

   a_cnt_bound : assert property (
      @(posedge clk) disable iff (rst)
      cnt_q <= MAX_CNT
   );
`endif

endmodule

// File: tb/tb_cv32e40p_instr_mem_responder.sv
// Bench for the instruction-memory responder: three configurations
// checked by a queue-based response model plus directed scenarios.
module tb_cv32e40p_instr_mem_responder;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [2:0]  stall;
   logic [31:0] addr [3];
   logic [31:0] srd  [3];
   logic [31:0] mem  [16384];

   wire  [2:0]  gnt;
   wire  [2:0]  rvalid;
   wire  [2:0]  err;
   wire  [2:0]  sram_req;
   wire  [2:0]  busy;
   wire  [31:0] rdata [3];
   wire  [31:0] saddr [3];
   wire  [13:0] sa0;
   wire  [13:0] sa1;
   wire  [9:0]  sa2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   exp_t q [3][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cv32e40p_instr_mem_responder_if bus0 ();
   cv32e40p_instr_mem_responder_if bus1 ();
   cv32e40p_instr_mem_responder_if bus2 ();

   assign bus0.instr_req_i  = req[0];
   assign bus1.instr_req_i  = req[1];
   assign bus2.instr_req_i  = req[2];
   assign bus0.instr_addr_i = addr[0];
   assign bus1.instr_addr_i = addr[1];
   assign bus2.instr_addr_i = addr[2];

   assign gnt    = {bus2.instr_gnt_o, bus1.instr_gnt_o,
                    bus0.instr_gnt_o};
   assign rvalid = {bus2.instr_rvalid_o, bus1.instr_rvalid_o,
                    bus0.instr_rvalid_o};
   assign err    = {bus2.instr_err_o, bus1.instr_err_o,
                    bus0.instr_err_o};
   assign rdata[0] = bus0.instr_rdata_o;
   assign rdata[1] = bus1.instr_rdata_o;
   assign rdata[2] = bus2.instr_rdata_o;
   assign saddr[0] = 32'(sa0);
   assign saddr[1] = 32'(sa1);
   assign saddr[2] = 32'(sa2);

   cv32e40p_instr_mem_responder #(
      .ADDR_WIDTH(16), .BASE_ADDR(32'h0),
      .RESP_LATENCY(1), .MAX_OUTSTANDING(2)
   ) u_d0 (
      .clk(clk), .rst(rst), .bus(bus0), .stall_i(stall[0]),
      .sram_req_o(sram_req[0]), .sram_addr_o(sa0),
      .sram_rdata_i(srd[0]), .busy_o(busy[0])
   );

   cv32e40p_instr_mem_responder #(
      .ADDR_WIDTH(16), .BASE_ADDR(32'h0),
      .RESP_LATENCY(3), .MAX_OUTSTANDING(4)
   ) u_d1 (
      .clk(clk), .rst(rst), .bus(bus1), .stall_i(stall[1]),
      .sram_req_o(sram_req[1]), .sram_addr_o(sa1),
      .sram_rdata_i(srd[1]), .busy_o(busy[1])
   );

   cv32e40p_instr_mem_responder #(
      .ADDR_WIDTH(12), .BASE_ADDR(32'h8000_0000),
      .RESP_LATENCY(3), .MAX_OUTSTANDING(2)
   ) u_d2 (
      .clk(clk), .rst(rst), .bus(bus2), .stall_i(stall[2]),
      .sram_req_o(sram_req[2]), .sram_addr_o(sa2),
      .sram_rdata_i(srd[2]), .busy_o(busy[2])
   );

   function automatic int lat_f(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int mo_f(int i);
      return (i == 1) ? 4 : 2;
   endfunction

   function automatic int aw_f(int i);
      return (i == 2) ? 12 : 16;
   endfunction

   function automatic logic [31:0] base_f(int i);
      return (i == 2) ? 32'h8000_0000 : 32'h0;
   endfunction

   function automatic logic [31:0] gen_addr(int i);
      logic [31:0] off;
      off = $urandom & ((32'h1 << aw_f(i)) - 32'h1);
      case ($urandom_range(0, 7))
         0:       off = off | (32'h1 << aw_f(i));
         1:       off = 32'h0 - 32'($urandom_range(1, 64));
         default: ;
      endcase
      return base_f(i) + off;
   endfunction

   task automatic chk(string tag, int inst,
                      logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d]: observed %h expected %h",
                tag, inst, obs, exp);
      end
   endtask

   // Behavioural SRAM: data one cycle after a read strobe, noise otherwise
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         srd[i] <= sram_req[i] ? mem[saddr[i][13:0]] : $urandom;
      end
   end

   // Reference model: each accept books one response due LAT cycles later
   always @(negedge clk) begin : model
      bit          due;
      bit          egnt;
      bit          inr;
      logic [31:0] off;
      exp_t        e;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            chk("rst_gnt", i, 32'(gnt[i]), 32'h0);
            chk("rst_sram_req", i, 32'(sram_req[i]), 32'h0);
            q[i].delete();
         end else begin
            due = (q[i].size() != 0) && (q[i][0].due == cyc);
            chk("busy", i, 32'(busy[i]), 32'(q[i].size() != 0));
            egnt = req[i] && !stall[i] &&
                   ((q[i].size() - int'(due)) < mo_f(i));
            chk("gnt", i, 32'(gnt[i]), 32'(egnt));
            off = addr[i] - base_f(i);
            inr = (off >> aw_f(i)) == 32'h0;
            chk("sram_req", i, 32'(sram_req[i]), 32'(egnt && inr));
            if (egnt && inr) chk("sram_addr", i, saddr[i], off >> 2);
            chk("rvalid", i, 32'(rvalid[i]), 32'(due));
            if (due) begin
               chk("rdata", i, rdata[i], q[i][0].data);
               chk("err", i, 32'(err[i]), 32'(q[i][0].err));
               void'(q[i].pop_front());
            end else begin
               chk("idle_rdata", i, rdata[i], 32'h0);
               chk("idle_err", i, 32'(err[i]), 32'h0);
            end
            if (egnt) begin
               e.due  = cyc + lat_f(i);
               e.err  = !inr;
               e.data = inr ? mem[off[15:2]] : 32'h0;
               q[i].push_back(e);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit [2:0] hold;
      int       nacc;
      rst   = 1'b1;
      req   = '0;
      stall = '0;
      for (int i = 0; i < 3; i++) addr[i] = 32'h0;
      for (int j = 0; j < 16384; j++) mem[j] = $urandom;
      mem[16'h40] = 32'h0041_0113;

      // Reset state, with a request already pending on d0
      repeat (2) @(posedge clk);
      #1;
      req[0]  = 1'b1;
      addr[0] = 32'h0000_0100;
      @(negedge clk);
      chk("reset_gnt", 0, 32'(gnt[0]), 32'h0);
      chk("reset_sram_req", 0, 32'(sram_req[0]), 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("reset_rvalid", i, 32'(rvalid[i]), 32'h0);
         chk("reset_busy", i, 32'(busy[i]), 32'h0);
         chk("reset_rdata", i, rdata[i], 32'h0);
      end

      // Basic fetch at 0x100
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("fetch_gnt", 0, 32'(gnt[0]), 32'h1);
      chk("fetch_sram_req", 0, 32'(sram_req[0]), 32'h1);
      chk("fetch_sram_addr", 0, saddr[0], 32'h40);
      next_cycle();
      req[0] = 1'b0;
      @(negedge clk);
      chk("fetch_rvalid", 0, 32'(rvalid[0]), 32'h1);
      chk("fetch_rdata", 0, rdata[0], 32'h0041_0113);
      chk("fetch_err", 0, 32'(err[0]), 32'h0);
      chk("fetch_busy", 0, 32'(busy[0]), 32'h1);

      // Out-of-window fetch
      next_cycle();
      req[0]  = 1'b1;
      addr[0] = 32'h0001_0000;
      @(negedge clk);
      chk("oor_gnt", 0, 32'(gnt[0]), 32'h1);
      chk("oor_sram_req", 0, 32'(sram_req[0]), 32'h0);
      next_cycle();
      req[0] = 1'b0;
      @(negedge clk);
      chk("oor_rvalid", 0, 32'(rvalid[0]), 32'h1);
      chk("oor_err", 0, 32'(err[0]), 32'h1);
      chk("oor_rdata", 0, rdata[0], 32'h0);

      // Stall with a response in flight
      next_cycle();
      req[0]  = 1'b1;
      addr[0] = 32'h0000_0200;
      @(negedge clk);
      chk("pre_stall_gnt", 0, 32'(gnt[0]), 32'h1);
      next_cycle();
      addr[0]  = 32'h0000_0204;
      stall[0] = 1'b1;
      @(negedge clk);
      chk("stall_gnt", 0, 32'(gnt[0]), 32'h0);
      chk("inflight_rvalid", 0, 32'(rvalid[0]), 32'h1);
      chk("inflight_rdata", 0, rdata[0], mem[16'h80]);
      repeat (2) begin
         next_cycle();
         @(negedge clk);
         chk("stall_gnt", 0, 32'(gnt[0]), 32'h0);
      end
      next_cycle();
      stall[0] = 1'b0;
      @(negedge clk);
      chk("unstall_gnt", 0, 32'(gnt[0]), 32'h1);
      chk("unstall_sram_addr", 0, saddr[0], 32'h81);
      next_cycle();
      req[0] = 1'b0;
      @(negedge clk);
      chk("unstall_rdata", 0, rdata[0], mem[16'h81]);

      // Latency 3, six back-to-back fetches
      for (int k = 0; k < 9; k++) begin
         next_cycle();
         req[1]  = (k < 6);
         addr[1] = (k < 6) ? 32'(4 * k) : 32'h0;
         @(negedge clk);
         if (k < 6) chk("burst_gnt", 1, 32'(gnt[1]), 32'h1);
         chk("burst_rvalid", 1, 32'(rvalid[1]), 32'(k >= 3));
         if (k >= 3) chk("burst_rdata", 1, rdata[1], mem[k-3]);
      end

      // Latency 3 capped at two outstanding
      nacc = 0;
      for (int k = 0; k < 9; k++) begin
         next_cycle();
         req[2]  = 1'b1;
         addr[2] = 32'h8000_0000 + 32'(4 * nacc);
         @(negedge clk);
         chk("throttle_gnt", 2, 32'(gnt[2]), 32'((k % 3) != 2));
         if (gnt[2]) nacc++;
      end
      next_cycle();
      req[2] = 1'b0;
      repeat (5) next_cycle();

      // Reset one cycle after two accepts
      req[1]  = 1'b1;
      addr[1] = 32'h0;
      @(negedge clk);
      chk("pre_rst_gnt", 1, 32'(gnt[1]), 32'h1);
      next_cycle();
      addr[1] = 32'h4;
      @(negedge clk);
      chk("pre_rst_gnt", 1, 32'(gnt[1]), 32'h1);
      next_cycle();
      req[1] = 1'b0;
      rst    = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_rvalid", 1, 32'(rvalid[1]), 32'h0);
         chk("post_rst_busy", 1, 32'(busy[1]), 32'h0);
         next_cycle();
      end
      req[1]  = 1'b1;
      addr[1] = 32'h0000_0100;
      @(negedge clk);
      chk("post_rst_gnt", 1, 32'(gnt[1]), 32'h1);
      chk("post_rst_sram_addr", 1, saddr[1], 32'h40);
      next_cycle();
      req[1] = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_wait", 1, 32'(rvalid[1]), 32'h0);
         next_cycle();
      end
      @(negedge clk);
      chk("post_rst_rvalid", 1, 32'(rvalid[1]), 32'h1);
      chk("post_rst_rdata", 1, rdata[1], 32'h0041_0113);
      chk("post_rst_err", 1, 32'(err[1]), 32'h0);

      // Random traffic; an ungranted request is held unchanged
      hold = '0;
      for (int n = 0; n < 400; n++) begin
         next_cycle();
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 3; i++) begin
            if (!hold[i]) begin
               req[i]  = ($urandom_range(0, 3) != 0);
               addr[i] = gen_addr(i);
            end
            stall[i] = ($urandom_range(0, 4) == 0);
         end
         @(negedge clk);
         hold = req & ~gnt & ~{3{rst}};
      end
      next_cycle();
      rst   = 1'b0;
      req   = '0;
      stall = '0;
      repeat (8) next_cycle();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("drained", i, 32'(q[i].size()), 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
